// File: rtl/seg_pkg.sv
// seg_pkg
// Shared constants and types for the seven-segment scanner.
//   SEG_BLANK    : segment pattern for a dark digit (all segments and dp off)
//   GLYPH_TABLE  : active-low a..g patterns for hex digits 0..F, index = nibble
//   blink_phase_e: blink phase of the scan, PHASE_ON lights blinking digits
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Bit 6 is segment a, bit 0 is segment g; a 0 lights the segment.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    typedef enum logic {
        PHASE_ON  = 1'b0,
        PHASE_OFF = 1'b1
    } blink_phase_e;

endpackage

// File: rtl/seg_dec.sv
// seg_dec
// Combinational hex-to-seven-segment decoder with decimal point.
//   nibble : hex value to show
//   dp     : decimal point, 1 = lit
//   seg    : active-low segments, seg[7:1] = a..g, seg[0] = dp
module seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    // Glyph lookup plus the inverted decimal point, since the panel is active-low.
    always_comb begin
        seg = {GLYPH_TABLE[nibble], ~dp};
    end

endmodule

// File: rtl/seg_scan.sv
// seg_scan
// Time-multiplexed driver for a common-anode style seven-segment display.
// A prescaler divides clk into digit slots; each slot lights one digit.
// New display contents are captured into a shadow copy by 'load' and only
// become visible at a frame boundary, so a frame never shows mixed data.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   load         : one-cycle strobe capturing data/dp/en_mask/blink_mask
//   data         : hex nibble per digit, digit i = data[4i+3:4i]
//   dp           : decimal point per digit, 1 = lit
//   en_mask      : 1 = digit displayed
//   blink_mask   : 1 = digit dark during the blink-off phase
//   seg          : registered active-low segments (a..g, dp)
//   an           : registered active-low digit select, at most one bit low
//   pending      : shadow holds data not yet moved to the active copy
module seg_scan
    import seg_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int CLK_DIV      = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     en_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  pending
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic                tick;
    logic                frame_end;

    logic [4*DIGITS-1:0] sh_data;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_en;
    logic [DIGITS-1:0]   sh_bm;

    logic [4*DIGITS-1:0] act_data;
    logic [DIGITS-1:0]   act_dp;
    logic [DIGITS-1:0]   act_en;
    logic [DIGITS-1:0]   act_bm;

    logic [FRM_W-1:0]    frm_cnt;
    blink_phase_e        phase_q;
    blink_phase_e        phase_d;

    logic [3:0]          cur_nibble;
    logic                cur_dp;
    logic                blank;
    logic [7:0]          dec_seg;
    logic [7:0]          seg_d;
    logic [DIGITS-1:0]   an_d;

    // The last prescaler count of the last digit slot closes a frame.
    assign tick      = (cnt == CNT_LAST);
    assign frame_end = tick && (idx == IDX_LAST);

    // Prescaler: counts clk cycles within one digit slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Digit index: advances once per slot and wraps at the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (tick) begin
            if (idx == IDX_LAST) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Shadow/active double buffer. A load landing exactly on the frame
    // boundary skips the shadow stage so it is shown in the very next frame
    // and leaves nothing pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_data  <= '0;
            sh_dp    <= '0;
            sh_en    <= '0;
            sh_bm    <= '0;
            act_data <= '0;
            act_dp   <= '0;
            act_en   <= '0;
            act_bm   <= '0;
            pending  <= 1'b0;
        end else if (load) begin
            sh_data <= data;
            sh_dp   <= dp;
            sh_en   <= en_mask;
            sh_bm   <= blink_mask;
            if (frame_end) begin
                act_data <= data;
                act_dp   <= dp;
                act_en   <= en_mask;
                act_bm   <= blink_mask;
                pending  <= 1'b0;
            end else begin
                pending  <= 1'b1;
            end
        end else if (frame_end && pending) begin
            act_data <= sh_data;
            act_dp   <= sh_dp;
            act_en   <= sh_en;
            act_bm   <= sh_bm;
            pending  <= 1'b0;
        end
    end

    // Blink state register plus the frame counter that paces it.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PHASE_ON;
            frm_cnt <= '0;
        end else begin
            phase_q <= phase_d;
            if (frame_end) begin
                if (frm_cnt == FRM_LAST) begin
                    frm_cnt <= '0;
                end else begin
                    frm_cnt <= frm_cnt + 1'b1;
                end
            end
        end
    end

    // Blink next-state: flip phase when the frame counter completes a period.
    always_comb begin
        phase_d = phase_q;
        if (frame_end && (frm_cnt == FRM_LAST)) begin
            case (phase_q)
                PHASE_ON:  phase_d = PHASE_OFF;
                PHASE_OFF: phase_d = PHASE_ON;
                default:   phase_d = PHASE_ON;
            endcase
        end
    end

    // Blink output: decide whether the digit in the current slot stays dark.
    always_comb begin
        blank = 1'b0;
        if (!act_en[idx]) begin
            blank = 1'b1;
        end else if (act_bm[idx] && (phase_q == PHASE_OFF)) begin
            blank = 1'b1;
        end
    end

    // Pick the nibble and decimal point of the digit currently being scanned.
    always_comb begin
        cur_nibble = act_data[{idx, 2'b00} +: 4];
        cur_dp     = act_dp[idx];
    end

    seg_dec u_dec (
        .nibble (cur_nibble),
        .dp     (cur_dp),
        .seg    (dec_seg)
    );

    // Next panel drive: one anode low for a lit digit, everything dark otherwise.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        if (!blank) begin
            an_d[idx] = 1'b0;
            seg_d     = dec_seg;
        end
    end

    // Output registers keep the panel pins glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule
